// File: rtl/mv_bram_loader_if.sv
// Stream and BRAM-port bundles for mv_bram_loader.
// The stream master drives data/valid/last; the BRAM master drives address, data, enables and clock.
interface mv_stream_if #(parameter int DATA_W = 32);
  logic [DATA_W-1:0] s_tdata;
  logic              s_tvalid;
  logic              s_tready;
  logic              s_tlast;

  modport master (output s_tdata, output s_tvalid, output s_tlast, input s_tready);
  modport slave  (input s_tdata, input s_tvalid, input s_tlast, output s_tready);
endinterface

interface mv_bram_if #(parameter int DATA_W = 32);
  logic [31:0]       BRAM_ADDR;
  logic [DATA_W-1:0] BRAM_WRDATA;
  logic [3:0]        BRAM_WE;
  logic              BRAM_CLK;

  modport master (output BRAM_ADDR, output BRAM_WRDATA, output BRAM_WE, output BRAM_CLK);
  modport slave  (input BRAM_ADDR, input BRAM_WRDATA, input BRAM_WE, input BRAM_CLK);
endinterface

// File: rtl/mv_bram_loader.sv
// Streams the vector and matrix image into the operand BRAM, then kicks the PE array and waits for it.
// Optional tlast framing check: define MV_LOADER_TLAST_CHECK_EN to add the sticky err_tlast output.
module mv_bram_loader #(
  parameter int L_RAM_SIZE = 3,
  parameter int ROW_SIZE   = 8,
  parameter int DATA_W     = 32
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic        load_start,
  mv_stream_if.slave  s_axis,
  mv_bram_if.master   bram,
  output logic        pe_start,
  input  logic        pe_done,
  output logic        busy,
  output logic        done
`ifdef MV_LOADER_TLAST_CHECK_EN
  ,
  output logic        err_tlast
`endif
);

  localparam int TOTAL = (2 ** L_RAM_SIZE) * (ROW_SIZE + 1);
  localparam int CW    = $clog2(TOTAL);
  localparam logic [CW-1:0] LAST_IDX = CW'(TOTAL - 1);

  typedef enum logic [2:0] {IDLE, LOAD, KICK, WAIT_PE, FIN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count;
  logic          hs;
  logic          is_last;

  assign s_axis.s_tready = (state == LOAD);
  assign hs              = s_axis.s_tvalid & s_axis.s_tready;
  assign is_last         = (count == LAST_IDX);
  assign bram.BRAM_CLK   = ~S_AXI_ACLK;

  assign pe_start = (state == KICK);
  assign done     = (state == FIN);
  assign busy     = (state != IDLE);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_start) state_nxt = LOAD;
      LOAD:    if (hs && is_last) state_nxt = KICK;
      KICK:    state_nxt = WAIT_PE;
      WAIT_PE: if (pe_done) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write port is registered: the accepted word appears on the BRAM port the cycle after its handshake.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      count            <= '0;
      bram.BRAM_ADDR   <= '0;
      bram.BRAM_WRDATA <= '0;
      bram.BRAM_WE     <= '0;
    end else begin
      bram.BRAM_WE <= '0;
      if (state == IDLE && load_start) begin
        count <= '0;
      end else if (hs) begin
        bram.BRAM_ADDR   <= {{(32-CW-2){1'b0}}, count, 2'b00};
        bram.BRAM_WRDATA <= s_axis.s_tdata;
        bram.BRAM_WE     <= '1;
        count            <= count + 1'b1;
      end
    end
  end

`ifdef MV_LOADER_TLAST_CHECK_EN
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN)                              err_tlast <= 1'b0;
    else if (state == IDLE && load_start)            err_tlast <= 1'b0;
    else if (hs && (s_axis.s_tlast != is_last))      err_tlast <= 1'b1;
  end
`else
  logic unused_tlast;
  assign unused_tlast = s_axis.s_tlast;
`endif

endmodule

// File: tb/tb_mv_bram_loader.sv
// Randomised self-checking bench for mv_bram_loader against a protocol-level reference model.
module tb_mv_bram_loader;
  localparam int TOTAL = 72;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic load_start = 1'b0;
  logic pe_done = 1'b0;
  logic pe_start, busy, done;
`ifdef MV_LOADER_TLAST_CHECK_EN
  logic err_tlast;
`endif

  mv_stream_if #(.DATA_W(32)) strm ();
  mv_bram_if   #(.DATA_W(32)) bram ();

  mv_bram_loader #(.L_RAM_SIZE(3), .ROW_SIZE(8), .DATA_W(32)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .load_start    (load_start),
    .s_axis        (strm.slave),
    .bram          (bram.master),
    .pe_start      (pe_start),
    .pe_done       (pe_done),
    .busy          (busy),
    .done          (done)
`ifdef MV_LOADER_TLAST_CHECK_EN
    ,
    .err_tlast     (err_tlast)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks load progress in words and the PE handshake phase.
  int          m_n = 0;
  bit          m_ready = 0, m_we = 0, m_pe = 0, m_wait = 0, m_done = 0, m_err = 0;
  logic [31:0] m_addr = '0, m_data = '0;
  bit          m_idle, m_start, m_hs, m_fin, n_wait, n_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n = 0; m_ready = 0; m_we = 0; m_pe = 0; m_wait = 0; m_done = 0; m_err = 0;
      m_addr = '0; m_data = '0;
    end else begin
      m_idle  = !(m_ready || m_pe || m_wait || m_done);
      m_start = m_idle && load_start;
      m_hs    = m_ready && strm.s_tvalid;
      m_fin   = m_hs && (m_n == TOTAL - 1);
      m_we    = m_hs;
      if (m_hs) begin
        m_addr = m_n * 4;
        m_data = strm.s_tdata;
      end
      if (m_start) m_err = 0;
      else if (m_hs && (strm.s_tlast != (m_n == TOTAL - 1))) m_err = 1;
      n_wait  = m_pe || (m_wait && !pe_done);
      n_done  = m_wait && pe_done;
      m_ready = m_start || (m_ready && !m_fin);
      if (m_start) m_n = 0;
      else if (m_hs) m_n++;
      m_pe   = m_fin;
      m_wait = n_wait;
      m_done = n_done;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("s_tready", strm.s_tready, m_ready);
      chk("BRAM_WE", bram.BRAM_WE, m_we ? 4'hF : 4'h0);
      chk("BRAM_ADDR", bram.BRAM_ADDR, m_addr);
      chk("BRAM_WRDATA", bram.BRAM_WRDATA, m_data);
      chk("pe_start", pe_start, m_pe);
      chk("done", done, m_done);
      chk("busy", busy, m_ready || m_pe || m_wait || m_done);
      chk("BRAM_CLK", bram.BRAM_CLK, 1'b1);
`ifdef MV_LOADER_TLAST_CHECK_EN
      chk("err_tlast", err_tlast, m_err);
`endif
    end
  end

  // BRAM image as committed on the BRAM clock edge.
  logic [31:0] mem [TOTAL];
  logic [31:0] sent [TOTAL];
  logic [31:0] first_addr;
  bit          first_seen;

  always @(posedge bram.BRAM_CLK) begin
    if (bram.BRAM_WE == 4'hF) begin
      if (!first_seen) begin
        first_addr = bram.BRAM_ADDR;
        first_seen = 1'b1;
      end
      if ((bram.BRAM_ADDR >> 2) < TOTAL) mem[bram.BRAM_ADDR >> 2] = bram.BRAM_WRDATA;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < TOTAL; i++) mem[i] = 32'hDEAD_BEEF;
    first_seen = 1'b0;
    first_addr = 32'hFFFF_FFFF;
  endtask

  task automatic start_load();
    @(posedge clk); #1 load_start = 1'b1;
    @(posedge clk); #1 load_start = 1'b0;
  endtask

  // mode 0: valid always high, data = index; mode 1: valid toggles, data = index; mode 2: random.
  task automatic stream(input int mode, input int tlast_idx, input int lim);
    int k = 0;
    int guard = 0;
    bit hs;
    while (k < lim && guard < 3000) begin
      case (mode)
        0:       strm.s_tvalid = 1'b1;
        1:       strm.s_tvalid = (guard % 2 == 0);
        default: strm.s_tvalid = ($urandom_range(0, 3) != 0);
      endcase
      strm.s_tdata = (mode == 2) ? $urandom : 32'(k);
      strm.s_tlast = (k == tlast_idx);
      @(negedge clk);
      hs = strm.s_tvalid && strm.s_tready;
      @(posedge clk); #1;
      if (hs) begin
        sent[k] = strm.s_tdata;
        k++;
      end
      guard++;
    end
    strm.s_tvalid = 1'b0;
    strm.s_tlast  = 1'b0;
    strm.s_tdata  = $urandom;
    if (k < lim) chk("stream timeout", k, lim);
  endtask

  task automatic finish_load(input bit poke);
    int g = 0;
    while (pe_start !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g == 200) chk("pe_start timeout", 0, 1);
    repeat (20) @(posedge clk);
    #1 pe_done = 1'b1;
    load_start = poke;
    @(posedge clk); #1;
    pe_done = 1'b0;
    load_start = 1'b0;
    g = 0;
    while (done !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g == 200) chk("done timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_image(input string nm);
    for (int i = 0; i < TOTAL; i++) chk(nm, mem[i], sent[i]);
  endtask

  initial begin
    strm.s_tvalid = 1'b0;
    strm.s_tlast  = 1'b0;
    strm.s_tdata  = '0;
    clear_mem();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset s_tready", strm.s_tready, 0);
    chk("reset BRAM_ADDR", bram.BRAM_ADDR, 0);
    chk("reset pe_start", pe_start, 0);

    // Load A: continuous stream of index values; second load_start poked during WAIT_PE.
    start_load();
    @(negedge clk);
    chk("s_tready after start", strm.s_tready, 1);
    @(posedge clk); #1;
    stream(0, TOTAL - 1, TOTAL);
    @(negedge clk);
    chk("kick pe_start", pe_start, 1);
    chk("kick last addr", bram.BRAM_ADDR, 32'h11C);
    chk("kick last data", bram.BRAM_WRDATA, 32'h47);
    chk("kick last we", bram.BRAM_WE, 4'hF);
    finish_load(1'b1);
    chk("image A word 5", mem[5], 32'h5);
    chk("image A word 71", mem[71], 32'h47);
    chk("image A first addr", first_addr, 0);
    @(negedge clk);
    chk("idle after poke", busy, 0);

    // Load B: toggled valid, index data; then Load C: random valid and data.
    clear_mem();
    start_load();
    stream(1, TOTAL - 1, TOTAL);
    finish_load(1'b0);
    check_image("image B");

    clear_mem();
    start_load();
    stream(2, TOTAL - 1, TOTAL);
    finish_load(1'b0);
    check_image("image C");

    // Abort after 30 words with an asynchronous reset, then reload from scratch.
    clear_mem();
    start_load();
    stream(2, TOTAL - 1, 30);
    #2 rst_n = 1'b0;
    #1;
    chk("async s_tready", strm.s_tready, 0);
    chk("async busy", busy, 0);
    chk("async BRAM_WE", bram.BRAM_WE, 0);
    chk("async BRAM_ADDR", bram.BRAM_ADDR, 0);
    chk("async BRAM_WRDATA", bram.BRAM_WRDATA, 0);
    chk("async pe_start", pe_start, 0);
    chk("async done", done, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    clear_mem();
    start_load();
    stream(2, TOTAL - 1, TOTAL);
    finish_load(1'b0);
    chk("reload first addr", first_addr, 0);
    check_image("image D");

`ifdef MV_LOADER_TLAST_CHECK_EN
    clear_mem();
    start_load();
    stream(2, 70, TOTAL);
    finish_load(1'b0);
    chk("err_tlast early", err_tlast, 1);
    check_image("image E");
    start_load();
    stream(2, TOTAL - 1, TOTAL);
    finish_load(1'b0);
    chk("err_tlast clean", err_tlast, 0);
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end
endmodule
